// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared widths, defaults and FSM encoding for the animation sequencer
package anim_pkg;

  localparam int ANGLE_W           = 9;
  localparam int ANGLE_MAX_DEFAULT = 360;
  localparam int V_ACTIVE_DEFAULT  = 480;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchronizer, stability counter, debounced level and rise pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_pix,
  input  logic resetn,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept the synchronized level only after it has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state registers
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/anim_sequencer.sv
// rtl/anim_sequencer.sv - per-frame rotation angle update with settle window, pause/step/direction controls
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int V_ACTIVE        = V_ACTIVE_DEFAULT,
  parameter int ANGLE_MAX       = ANGLE_MAX_DEFAULT,
  parameter int ANGLE_STEP      = 1,
  parameter int FRAMES_PER_STEP = 1,
  parameter int SETTLE_CYCLES   = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk_pix,
  input  logic               resetn,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               btn_pause,
  input  logic               btn_step,
  input  logic               btn_dir,
  output logic [ANGLE_W-1:0] angle,
  output logic               angle_valid,
  output logic               paused,
  output logic [15:0]        frame_count
);

  localparam logic [9:0] V_ACT10 = 10'(V_ACTIVE);
  localparam logic [9:0] MAX10   = 10'(ANGLE_MAX);
  localparam logic [9:0] STEP10  = 10'(ANGLE_STEP);
  localparam int PW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(FRAMES_PER_STEP - 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [PW-1:0]      prescale_q, prescale_d;
  logic               paused_q, paused_d;
  logic               step_pending_q, step_pending_d;

  logic pause_level, pause_rise;
  logic step_level, step_rise;
  logic dir_level, dir_rise;
  logic unused_debounce;
  logic tick;
  logic [9:0] angle_ext, inc_sum, inc_angle, dec_angle, next_angle;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .btn_i   (btn_pause),
    .level_o (pause_level),
    .rise_o  (pause_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .btn_i   (btn_step),
    .level_o (step_level),
    .rise_o  (step_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .btn_i   (btn_dir),
    .level_o (dir_level),
    .rise_o  (dir_rise)
  );

  // Pause and step act on edges; direction acts on level
  assign unused_debounce = pause_level ^ step_level ^ dir_rise;

  assign tick = (x == 10'd0) && (y == V_ACT10);

  // Modular next angle, widened to 10 bits so angle+step never overflows
  always_comb begin
    angle_ext  = {1'b0, angle_q};
    inc_sum    = angle_ext + STEP10;
    inc_angle  = (inc_sum >= MAX10) ? (inc_sum - MAX10) : inc_sum;
    dec_angle  = (angle_ext < STEP10) ? (angle_ext + MAX10 - STEP10) : (angle_ext - STEP10);
    next_angle = dir_level ? dec_angle : inc_angle;
  end

  // Sequencer next state: wait for blanking, update once, then hold the settle window
  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    angle_d        = angle_q;
    frame_count_d  = frame_count_q;
    prescale_d     = prescale_q;
    paused_d       = paused_q ^ pause_rise;
    step_pending_d = step_pending_q;
    case (state_q)
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        frame_count_d = frame_count_q + 16'd1;
        prescale_d    = (prescale_q == PRE_LAST) ? '0 : prescale_q + 1'b1;
        if (step_pending_q || (!paused_q && (prescale_q == PRE_LAST))) begin
          angle_d = next_angle[ANGLE_W-1:0];
        end
        step_pending_d = 1'b0;
        settle_cnt_d   = '0;
        state_d        = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = ST_WAIT;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      default: begin
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
    endcase
    // A step press only registers against the post-toggle pause state, so unpause wins
    if (step_rise && paused_d) begin
      step_pending_d = 1'b1;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_SETTLE;
      settle_cnt_q   <= '0;
      angle_q        <= '0;
      frame_count_q  <= '0;
      prescale_q     <= '0;
      paused_q       <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      angle_q        <= angle_d;
      frame_count_q  <= frame_count_d;
      prescale_q     <= prescale_d;
      paused_q       <= paused_d;
      step_pending_q <= step_pending_d;
    end
  end

  assign angle       = angle_q;
  assign angle_valid = (state_q == ST_WAIT);
  assign paused      = paused_q;
  assign frame_count = frame_count_q;

endmodule
